// File: rtl/vga_screen_sequencer_if.sv
// MMIO video-slot bus bundle for the title-screen sequencer.
// The bus master drives the strobes and the sequencer returns read data.
interface vga_screen_sequencer_if;
    logic        cs;
    logic        write;
    logic        read;
    logic [13:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output cs, write, read, addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  cs, write, read, addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/vga_screen_sequencer.sv
// Frame-synchronous title-screen sequencer:
// idle, title hold, blink, fade-out, then game.
module vga_screen_sequencer #(
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 30,
    parameter int FADE_RATE    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [10:0]                   x,
    input  logic [10:0]                   y,
    vga_screen_sequencer_if.slave         bus,
    output logic                          title_bypass,
    output logic                          game_bypass,
    output logic [3:0]                    fade_level,
    output logic                          seq_done
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] TITLE = 3'd1;
    localparam logic [2:0] BLINK = 3'd2;
    localparam logic [2:0] FADE  = 3'd3;
    localparam logic [2:0] GAME  = 3'd4;

    logic [2:0]  state, nxt;
    logic [15:0] frame_cnt, hold_reg, hold_act, hold_eff;
    logic [16:0] cnt_nxt;
    logic        start_pend, skip_pend, zero, zero_d, tick;
    logic        wr, wr_ctrl, abort, take_start, take_skip;
    logic        blink_hit, fade_hit;
    logic        unused_bus;

    // x/y dwell for several clocks per pixel, so edge-detect frame origin
    assign zero     = (x == 11'd0) && (y == 11'd0);
    assign tick     = zero && !zero_d;

    assign wr       = bus.cs && bus.write;
    assign wr_ctrl  = wr && (bus.addr[1:0] == 2'd0);
    assign abort    = wr_ctrl && bus.wr_data[2];

    assign cnt_nxt   = {1'b0, frame_cnt} + 17'd1;
    assign hold_eff  = (hold_act == 16'd0) ? 16'd1 : hold_act;
    assign blink_hit = (cnt_nxt % 17'(BLINK_FRAMES)) == 17'd0;
    assign fade_hit  = (cnt_nxt % 17'(FADE_RATE)) == 17'd0;
    assign seq_done  = (state == GAME);

    assign unused_bus = &{1'b0, bus.read, bus.addr[13:2], bus.wr_data[31:16]};

    always_comb begin
        nxt        = state;
        take_start = 1'b0;
        take_skip  = 1'b0;
        if (tick) begin
            unique case (state)
                IDLE: if (start_pend) begin
                    nxt        = TITLE;
                    take_start = 1'b1;
                end
                TITLE: if (skip_pend) begin
                    nxt       = FADE;
                    take_skip = 1'b1;
                end else if (cnt_nxt == {1'b0, hold_eff}) begin
                    nxt = BLINK;
                end
                BLINK: if (skip_pend) begin
                    nxt       = FADE;
                    take_skip = 1'b1;
                end
                FADE: if (fade_level == 4'd0) nxt = GAME;
                GAME: begin
                    take_skip = 1'b1;
                    if (start_pend) begin
                        nxt        = TITLE;
                        take_start = 1'b1;
                    end
                end
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            frame_cnt    <= 16'd0;
            hold_reg     <= 16'(HOLD_FRAMES);
            hold_act     <= 16'(HOLD_FRAMES);
            start_pend   <= 1'b0;
            skip_pend    <= 1'b0;
            zero_d       <= 1'b0;
            title_bypass <= 1'b1;
            game_bypass  <= 1'b1;
            fade_level   <= 4'd15;
        end else begin
            zero_d <= zero;
            if (wr && bus.addr[1:0] == 2'd1) hold_reg <= bus.wr_data[15:0];
            if (abort) begin
                state        <= IDLE;
                frame_cnt    <= 16'd0;
                start_pend   <= 1'b0;
                skip_pend    <= 1'b0;
                title_bypass <= 1'b1;
                game_bypass  <= 1'b1;
                fade_level   <= 4'd15;
            end else begin
                // new writes win over consumption so a tick-cycle write survives
                start_pend <= (start_pend && !take_start) || (wr_ctrl && bus.wr_data[0]);
                skip_pend  <= (skip_pend && !take_skip) || (wr_ctrl && bus.wr_data[1]);
                if (tick) begin
                    state <= nxt;
                    if (nxt != state) begin
                        frame_cnt    <= 16'd0;
                        title_bypass <= (nxt == IDLE) || (nxt == GAME);
                        game_bypass  <= (nxt != FADE) && (nxt != GAME);
                        fade_level   <= 4'd15;
                        if (nxt == TITLE) hold_act <= hold_reg;
                    end else begin
                        if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
                        if (state == BLINK && blink_hit) title_bypass <= !title_bypass;
                        if (state == FADE && fade_hit) fade_level <= fade_level - 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.rd_data = 32'd0;
        unique case (bus.addr[1:0])
            2'd0: bus.rd_data = {29'd0, skip_pend, start_pend, seq_done};
            2'd1: bus.rd_data = {16'd0, hold_reg};
            2'd2: bus.rd_data = {13'd0, state, frame_cnt};
            2'd3: bus.rd_data = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_vga_screen_sequencer.sv
// Directed bench for the title-screen sequencer on a tiny 4x2 raster.
// Expected values are hand-derived from the frame schedule.
module tb_vga_screen_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x = 11'd0;
    logic [10:0] y = 11'd0;
    logic        title_bypass, game_bypass, seq_done;
    logic [3:0]  fade_level;
    logic [31:0] v;
    int          checks = 0;
    int          errors = 0;
    int          pix_div = 1;
    event        frame_ev;

    vga_screen_sequencer_if bus ();

    vga_screen_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .bus          (bus),
        .title_bypass (title_bypass),
        .game_bypass  (game_bypass),
        .fade_level   (fade_level),
        .seq_done     (seq_done)
    );

    always #50 clk = ~clk;

    // raster: 4 columns x 2 rows, pix_div clocks per pixel
    initial begin
        forever begin
            for (int yy = 0; yy < 2; yy++) begin
                for (int xx = 0; xx < 4; xx++) begin
                    @(negedge clk);
                    x = 11'(xx);
                    y = 11'(yy);
                    if (xx == 0 && yy == 0) ->frame_ev;
                    repeat (pix_div - 1) @(negedge clk);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.addr = {12'd0, a};
        #1;
        d = bus.rd_data;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic out_chk(input string tag, input logic tb, input logic gb,
                           input logic sd, input logic [3:0] f);
        chk(tag, {25'd0, title_bypass, game_bypass, seq_done, fade_level},
                 {25'd0, tb, gb, sd, f});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cs      = 1'b1;
        bus.write   = 1'b1;
        bus.addr    = {12'd0, a};
        bus.wr_data = d;
        @(posedge clk);
        #1;
        bus.cs    = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) @(frame_ev);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.cs = 1'b0;
        bus.write = 1'b0;
        bus.read = 1'b0;
        bus.addr = 14'd0;
        bus.wr_data = 32'd0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        out_chk("rst_out", 1'b1, 1'b1, 1'b0, 4'd15);
        rd_chk("rst_ctrl", 2'd0, 32'h0);
        rd_chk("rst_hold", 2'd1, 32'd120);
        rd_chk("rst_stat", 2'd2, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // idle with no writes
        frames(10);
        rd(2'd2, v);
        chk("idle_state", {29'd0, v[18:16]}, 32'd0);
        rd_chk("idle_ctrl", 2'd0, 32'h0);
        out_chk("idle_out", 1'b1, 1'b1, 1'b0, 4'd15);

        // start, hold 120, blink toggles
        wr(2'd0, 32'h1);
        rd_chk("start_pend", 2'd0, 32'h2);
        frames(1);
        rd_chk("title_entry", 2'd2, 32'h10000);
        out_chk("title_out", 1'b0, 1'b1, 1'b0, 4'd15);
        rd_chk("start_taken", 2'd0, 32'h0);
        frames(119);
        rd_chk("title_119", 2'd2, 32'h10077);
        frames(1);
        rd_chk("blink_entry", 2'd2, 32'h20000);
        out_chk("blink_out", 1'b0, 1'b1, 1'b0, 4'd15);
        frames(29);
        out_chk("blink_29", 1'b0, 1'b1, 1'b0, 4'd15);
        frames(1);
        out_chk("blink_30", 1'b1, 1'b1, 1'b0, 4'd15);
        frames(30);
        out_chk("blink_60", 1'b0, 1'b1, 1'b0, 4'd15);
        frames(30);
        out_chk("blink_90", 1'b1, 1'b1, 1'b0, 4'd15);
        rd_chk("blink_cnt90", 2'd2, 32'h2005A);

        // skip into fade, fade to game
        wr(2'd0, 32'h2);
        rd_chk("skip_pend", 2'd0, 32'h4);
        frames(1);
        rd_chk("fade_entry", 2'd2, 32'h30000);
        out_chk("fade_out", 1'b0, 1'b0, 1'b0, 4'd15);
        frames(3);
        out_chk("fade_3", 1'b0, 1'b0, 1'b0, 4'd15);
        frames(1);
        out_chk("fade_4", 1'b0, 1'b0, 1'b0, 4'd14);
        frames(28);
        out_chk("fade_32", 1'b0, 1'b0, 1'b0, 4'd7);
        frames(28);
        out_chk("fade_60", 1'b0, 1'b0, 1'b0, 4'd0);
        rd_chk("fade_60_st", 2'd2, 32'h3003C);
        frames(1);
        rd_chk("game_entry", 2'd2, 32'h40000);
        out_chk("game_out", 1'b1, 1'b0, 1'b1, 4'd15);
        rd_chk("game_ctrl", 2'd0, 32'h1);

        // short hold, replay from game
        wr(2'd1, 32'h3);
        rd_chk("hold_wr", 2'd1, 32'h3);
        wr(2'd0, 32'h1);
        frames(1);
        rd_chk("replay_title", 2'd2, 32'h10000);
        out_chk("replay_out", 1'b0, 1'b1, 1'b0, 4'd15);
        frames(2);
        rd_chk("hold3_t2", 2'd2, 32'h10002);
        frames(1);
        rd_chk("hold3_blink", 2'd2, 32'h20000);
        wr(2'd1, 32'h0);
        wr(2'd0, 32'h2);
        frames(1);
        rd_chk("fade2_entry", 2'd2, 32'h30000);
        frames(61);
        rd_chk("game2_entry", 2'd2, 32'h40000);
        wr(2'd0, 32'h1);
        frames(1);
        rd_chk("hold0_title", 2'd2, 32'h10000);
        frames(1);
        rd_chk("hold0_blink", 2'd2, 32'h20000);

        // abort beats start mid-fade
        wr(2'd0, 32'h2);
        frames(1);
        frames(32);
        out_chk("fade7", 1'b0, 1'b0, 1'b0, 4'd7);
        wr(2'd0, 32'h5);
        rd_chk("abort_stat", 2'd2, 32'h0);
        out_chk("abort_out", 1'b1, 1'b1, 1'b0, 4'd15);
        rd_chk("abort_ctrl", 2'd0, 32'h0);
        frames(1);
        rd_chk("abort_stay", 2'd2, 32'h1);

        // slow pixels: one tick per frame, then async reset
        pix_div = 4;
        wr(2'd1, 32'h5);
        wr(2'd0, 32'h1);
        frames(1);
        rd_chk("slow_title", 2'd2, 32'h10000);
        frames(1);
        rd_chk("slow_cnt1", 2'd2, 32'h10001);
        frames(3);
        rd_chk("slow_cnt4", 2'd2, 32'h10004);
        frames(1);
        rd_chk("slow_blink", 2'd2, 32'h20000);
        frames(2);
        rd_chk("slow_blink2", 2'd2, 32'h20002);
        reset = 1'b1;
        #1;
        out_chk("areset_out", 1'b1, 1'b1, 1'b0, 4'd15);
        rd_chk("areset_hold", 2'd1, 32'd120);
        rd_chk("areset_stat", 2'd2, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // start and skip together from idle
        wr(2'd0, 32'h3);
        rd_chk("both_pend", 2'd0, 32'h6);
        frames(1);
        rd(2'd2, v);
        chk("both_title", {29'd0, v[18:16]}, 32'd1);
        rd_chk("both_skip_left", 2'd0, 32'h4);
        frames(1);
        rd_chk("both_fade", 2'd2, 32'h30000);
        rd_chk("both_ctrl", 2'd0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
